adc_responder: RTL and testbench

Behavioural stand-in for the ADC/DUT end of the test-fixture link. It accepts DAC command words from the test sequencer, waits a programmable conversion latency, and returns one 16-bit result with a single-cycle `adc_ready` strobe. It sits opposite the test FSM in closed-loop benches and on the FPGA self-test path. Its response modes produce passing, echoing and deliberately failing data, so that the sequencer's error counting can be exercised.

---
 rtl/adc_resp_pkg.sv | 9 +
 rtl/resp_delay_ctr.sv | 31 +++
 rtl/adc_responder.sv | 104 ++++++++++
 tb/tb_adc_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: shared types and constants for the ADC responder.
//   resp_mode_t : response mode selector (GOLDEN, ECHO, INVERT, FAULT)
//   state_t     : responder state (OFF, IDLE, CONVERT, RESPOND)
//   FAULT_XOR   : mask applied to a corrupted fault-mode response
package adc_resp_pkg;
    typedef enum logic [1:0] {GOLDEN, ECHO, INVERT, FAULT} resp_mode_t;
    typedef enum logic [1:0] {OFF, IDLE, CONVERT, RESPOND} state_t;
    localparam logic [15:0] FAULT_XOR = 16'h0001;
endpackage

// File: rtl/resp_delay_ctr.sv
// resp_delay_ctr: loadable conversion-latency down-counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (0 is loaded as 1)
//   load_val_i  : latency in cycles
//   abort_i     : clear the count (has priority over load)
//   done_o      : count equals 1, i.e. the next edge ends the conversion
module resp_delay_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         abort_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (abort_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= (load_val_i == '0) ? W'(1) : load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign done_o = (cnt_q == W'(1));
endmodule

// File: rtl/adc_responder.sv
// adc_responder: behavioural ADC stand-in returning one result per command after a programmable latency.
//   clk, rst_n   : clock, asynchronous active-low reset
//   power_en     : supply enable; low forces OFF and clears counters
//   cmd_valid    : strobe qualifying dac_cmd
//   dac_cmd      : command word
//   latency      : conversion cycles (0 treated as 1), sampled at acceptance
//   resp_mode    : 00 golden, 01 echo, 10 inverted echo, 11 fault-inject
//   fault_period : in fault mode corrupt every Nth response (0 = never)
//   adc_data     : result, held between responses
//   adc_ready    : one-cycle result strobe
//   busy         : conversion in progress
//   cmd_count    : accepted command count
//   overrun      : sticky, a command arrived during a conversion
module adc_responder #(
    parameter int                DATA_W = 16,
    parameter int                LAT_W  = 8,
    parameter logic [DATA_W-1:0] GOLDEN = DATA_W'(16'h5555)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              power_en,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] dac_cmd,
    input  logic [LAT_W-1:0]  latency,
    input  logic [1:0]        resp_mode,
    input  logic [LAT_W-1:0]  fault_period,
    output logic [DATA_W-1:0] adc_data,
    output logic              adc_ready,
    output logic              busy,
    output logic [15:0]       cmd_count,
    output logic              overrun
);
    adc_resp_pkg::state_t     state_q, state_d;
    adc_resp_pkg::resp_mode_t mode_q;
    logic [DATA_W-1:0]        cmd_q, data_q, result;
    logic [LAT_W-1:0]         fault_q, fault_next;
    logic [15:0]              count_q;
    logic                     overrun_q, done, accept, respond, fault_hit;

    resp_delay_ctr #(.W(LAT_W)) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (accept),
        .load_val_i(latency),
        .abort_i   (!power_en),
        .done_o    (done)
    );

    always_comb begin
        accept     = power_en && cmd_valid &&
                     (state_q == adc_resp_pkg::IDLE || state_q == adc_resp_pkg::RESPOND);
        respond    = power_en && state_q == adc_resp_pkg::CONVERT && done;
        state_d    = !power_en                          ? adc_resp_pkg::OFF :
                     accept                             ? adc_resp_pkg::CONVERT :
                     respond                            ? adc_resp_pkg::RESPOND :
                     state_q == adc_resp_pkg::CONVERT   ? adc_resp_pkg::CONVERT :
                                                          adc_resp_pkg::IDLE;
        // The counter value after this response decides corruption, so the Nth response is the faulty one.
        fault_next = fault_q + LAT_W'(1);
        fault_hit  = fault_period != '0 && fault_next == fault_period;
        result     = mode_q == adc_resp_pkg::ECHO   ? cmd_q :
                     mode_q == adc_resp_pkg::INVERT ? ~cmd_q :
                     mode_q == adc_resp_pkg::FAULT && fault_hit ? GOLDEN ^ DATA_W'(adc_resp_pkg::FAULT_XOR) :
                                                      GOLDEN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= adc_resp_pkg::OFF;
            mode_q    <= adc_resp_pkg::GOLDEN;
            cmd_q     <= '0;
            data_q    <= '0;
            fault_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!power_en) begin
                fault_q   <= '0;
                count_q   <= '0;
                overrun_q <= 1'b0;
            end else begin
                if (accept) begin
                    cmd_q   <= dac_cmd;
                    mode_q  <= adc_resp_pkg::resp_mode_t'(resp_mode);
                    count_q <= count_q + 16'd1;
                end
                if (cmd_valid && state_q == adc_resp_pkg::CONVERT)
                    overrun_q <= 1'b1;
                if (respond) begin
                    data_q <= result;
                    if (mode_q == adc_resp_pkg::FAULT)
                        fault_q <= fault_hit ? '0 : fault_next;
                end
            end
        end
    end

    assign adc_data  = data_q;
    assign adc_ready = state_q == adc_resp_pkg::RESPOND;
    assign busy      = state_q == adc_resp_pkg::CONVERT;
    assign cmd_count = count_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder: scoreboard bench for adc_responder with directed and randomized traffic.
module tb_adc_responder;
    logic        clk = 0, rst_n = 0, power_en = 0, cmd_valid = 0;
    logic [15:0] dac_cmd = 0;
    logic [7:0]  latency = 0, fault_period = 0;
    logic [1:0]  resp_mode = 0;
    logic [15:0] adc_data, cmd_count;
    logic        adc_ready, busy, overrun;

    adc_responder dut (
        .clk(clk), .rst_n(rst_n), .power_en(power_en), .cmd_valid(cmd_valid),
        .dac_cmd(dac_cmd), .latency(latency), .resp_mode(resp_mode),
        .fault_period(fault_period), .adc_data(adc_data), .adc_ready(adc_ready),
        .busy(busy), .cmd_count(cmd_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          n;
    } exp_t;

    exp_t        q[$];
    exp_t        x;
    int          checks = 0, errors = 0;
    int          e = 0, resp_edge = -1, cnt = 0, fcnt = 0;
    bit          on = 0, ovr = 0, exp_r;
    logic [15:0] last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic logic [15:0] expect_result(input logic [1:0] mode, input logic [15:0] c);
        if (mode == 2'd1) return c;
        if (mode == 2'd2) return ~c;
        if (mode == 2'd0) return 16'h5555;
        fcnt = (fcnt + 1) % 256;
        if (fault_period != 0 && fcnt == int'(fault_period)) begin
            fcnt = 0;
            return 16'h5554;
        end
        return 16'h5555;
    endfunction

    // Reference model: per edge, decides acceptance from the rules and queues the expected response.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on = 0; resp_edge = -1; cnt = 0; ovr = 0; fcnt = 0; last = 0;
            q.delete();
        end else begin
            e++;
            if (!power_en) begin
                if (q.size() != 0 && q[$].n >= e) void'(q.pop_back());
                on = 0; resp_edge = -1; cnt = 0; ovr = 0; fcnt = 0;
            end else if (!on) begin
                on = 1;
            end else if (cmd_valid) begin
                if (e <= resp_edge) ovr = 1;
                else begin
                    cnt = (cnt + 1) % 65536;
                    resp_edge = e + ((latency == 0) ? 1 : int'(latency));
                    q.push_back('{expect_result(resp_mode, dac_cmd), resp_edge});
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmd_count", cmd_count, cnt);
            chk("overrun", overrun, ovr);
            chk("busy", busy, on && e < resp_edge);
            exp_r = q.size() != 0 && q[0].n <= e;
            chk("adc_ready", adc_ready, exp_r);
            if ((adc_ready || exp_r) && q.size() != 0) begin
                x = q.pop_front();
                if (adc_ready) begin
                    chk("resp_edge", e, x.n);
                    chk("resp_data", adc_data, x.d);
                    last = x.d;
                end
            end
            chk("adc_data_hold", adc_data, last);
        end
    end

    task automatic send(input logic [15:0] c, input logic [7:0] l, input logic [1:0] m);
        @(negedge clk);
        cmd_valid = 1; dac_cmd = c; latency = l; resp_mode = m;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_adc_data"}, adc_data, 0);
        chk({tag, "_adc_ready"}, adc_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cmd_count"}, cmd_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #1 chk_zero("reset");
        idle(2);
        rst_n = 1; power_en = 1;
        idle(2);
        send(16'hAAAA, 3, 2'd0);
        idle(5);
        send(16'h1234, 0, 2'd1);
        send(16'h1234, 0, 2'd2);
        idle(3);
        fault_period = 3;
        repeat (6) send(16'($urandom), 1, 2'd3);
        idle(3);
        send(16'h0F0F, 5, 2'd1);
        send(16'h0F0E, 5, 2'd1);
        idle(8);
        send(16'h1111, 5, 2'd1);
        idle(1);
        power_en = 0;
        idle(1);
        power_en = 1;
        idle(2);
        send(16'h2222, 2, 2'd2);
        idle(5);
        fault_period = 2;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cmd_valid = ($urandom_range(0, 2) == 0);
            dac_cmd   = 16'($urandom);
            latency   = 8'($urandom_range(0, 4));
            resp_mode = 2'($urandom);
            power_en  = ($urandom_range(0, 40) != 0);
        end
        @(negedge clk);
        cmd_valid = 0; power_en = 1;
        idle(10);
        send(16'h3333, 2, 2'd1);
        for (int i = 0; i < 10 && !adc_ready; i++) @(negedge clk);
        chk("reach_respond", adc_ready, 1);
        #2 rst_n = 0;
        #1 chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1;
        idle(3);
        send(16'h4444, 1, 2'd2);
        idle(4);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
